otopilot_kontrol_gen: RTL and testbench
=======================================

// Module: otopilot_kontrol_gen
// PURPOSE
//   Parametrised altitude autopilot: successor of the fixed-width autopilot FSM.
//   - Fuses the GNSS and altimeter altitude readings.
//   - Drives a bidirectional motor command toward a latched target altitude, with a tolerance band.
//   - Confirms arrival only after N consecutive in-band samples.
//   - Faults on invalid targets or on persistent sensor disagreement; the fault is sticky.
// PARAMETERS
//   ALT_W       16   width of gnss_i / altimetre_i (unsigned)
//   HEDEF_W     8    width of hedef_yukseklik_i (unsigned)
//   TOLERANS    2    half-width of the in-band window around the target, inclusive
//   SAPMA_ESIK  16   max allowed |gnss_i - altimetre_i| before a sample counts as disagreeing
//   ONAY_SAYI   3    consecutive in-band samples needed to declare target reached (>=1)
//   HATA_SAYI   4    consecutive disagreeing samples needed to fault (>=1)
//   MAX_HEDEF   100  largest accepted target; larger targets, and 0, fault
// PORTS
//   clk                  in   1        system clock, rising edge
//   rst_n                in   1        asynchronous active-low reset
//   gnss_i               in   ALT_W    GNSS altitude
//   altimetre_i          in   ALT_W    barometric altitude
//   hedef_yukseklik_i    in   HEDEF_W  target altitude, valid when yukseklik_bilgisi_i=1
//   yukseklik_bilgisi_i  in   1        target valid strobe; level-sampled every edge
//   hata_temizle_i       in   1        clears the HATA state (one-cycle pulse)
//   motor_o              out  2        00 stop, 01 climb, 10 descend (11 never driven)
//   yesil_led_o          out  1        target reached and held
//   kirmizi_led_o        out  1        fault
//   durum_o              out  3        current state encoding, for debug
// BEHAVIOUR
//   Reset and timing
//   - rst_n=0, at any time: state BOSTA; motor_o=00; both LEDs=0; durum_o=0.
//   - All counters and the target register clear to 0.
//   - All outputs are registered and reflect inputs sampled at the previous rising edge (1-cycle latency).
//   Arithmetic
//   - fuse  = (gnss_i + altimetre_i) >> 1, with the sum computed at ALT_W+1 bits (no overflow).
//   - sapma = |gnss_i - altimetre_i|, at ALT_W bits.
//   - hedef is zero-extended to ALT_W.
//   - alt_sinir = max(hedef - TOLERANS, 0), clamped with no underflow. ust_sinir = hedef + TOLERANS.
//   - In-band means alt_sinir <= fuse <= ust_sinir, both bounds inclusive.
//   States (durum_o): BOSTA=0, TAKIP=1, KORU=2, HATA=3
//   BOSTA
//   - motor_o=00, LEDs off.
//   - On yukseklik_bilgisi_i=1: if hedef_yukseklik_i==0 or >MAX_HEDEF -> HATA; else latch the target -> TAKIP.
//   TAKIP
//   - motor_o = 01 if fuse<alt_sinir, 10 if fuse>ust_sinir, else 00.
//   - In-band counter increments on in-band samples and clears on out-of-band samples.
//   - The edge on which the counter reaches ONAY_SAYI -> KORU (yesil=1 after that edge).
//   KORU
//   - yesil_led_o=1; motor_o keeps correcting by the same rule.
//   - Out-of-band counter increments on out-of-band samples and clears on in-band samples.
//   - Reaching ONAY_SAYI -> TAKIP with yesil=0 and the in-band counter cleared.
//   Disagreement (TAKIP and KORU)
//   - Any sample with sapma>SAPMA_ESIK increments the disagreement counter; an agreeing sample clears it.
//   - Reaching HATA_SAYI -> HATA.
//   - A disagreeing sample still drives motor_o from fuse.
//   Retarget (TAKIP and KORU)
//   - yukseklik_bilgisi_i=1 re-validates and re-latches the target.
//   - Valid target -> TAKIP with all counters cleared. Invalid target -> HATA.
//   - yukseklik_bilgisi_i=0 keeps the latched target; it is not a stop command.
//   HATA
//   - kirmizi_led_o=1, motor_o=00, yesil=0. Sticky.
//   - Exits only on hata_temizle_i=1 (-> BOSTA, counters cleared) or on reset.
//   Priority on the same edge
//   - reset > hata_temizle_i > invalid target > disagreement fault > retarget > band logic.
//   - In TAKIP/KORU, a sample that is both in-band and disagreeing counts for both counters.
//     If the disagreement fault and the band transition coincide, HATA wins.
// TESTING
//   1. Reset 2 cycles -> motor_o=00, LEDs=00, durum_o=0. Assert rst_n=0 mid-TAKIP -> outputs 0 without waiting for a clock edge.
//   2. bilgisi=1, hedef=110 -> next edge kirmizi=1, motor=00.
//      Stays HATA with bilgisi=1, hedef=50. hata_temizle_i pulse -> BOSTA. Repeat with hedef=0 -> HATA.
//   3. hedef=50 latched; gnss=20/alt=36 (fuse 28) -> motor=01. gnss=56/alt=72 (fuse 64) -> motor=10.
//      fuse=48 and fuse=52 -> motor=00 (inclusive band edges).
//   4. hedef=50; gnss=46/alt=52 (fuse 49) for 3 edges -> yesil=1 after the 3rd edge.
//      2 in-band samples then 1 out-of-band sample -> no yesil. In KORU, 3 samples at fuse 60 -> TAKIP, yesil=0.
//   5. gnss=36/alt=60 (sapma 24) for 4 edges -> kirmizi=1.
//      3 disagreeing samples then gnss=45/alt=45 -> no fault, counter cleared.
//   6. Retarget in KORU: hedef 50 -> 30 with fuse 49 -> TAKIP, motor=10, yesil=0.
//      Retarget to hedef=1, TOLERANS=2 -> alt_sinir clamps to 0; fuse=0 counts as in-band.

Source files
------------

// File: rtl/otopilot_kontrol_gen_if.sv
// Sensor/target/operator inputs and motor/indicator outputs of the altitude autopilot.
// The controller takes the slave side of this bundle.
interface otopilot_kontrol_gen_if #(
  parameter int ALT_W   = 16,
  parameter int HEDEF_W = 8
);
  logic [ALT_W-1:0]   gnss_i;
  logic [ALT_W-1:0]   altimetre_i;
  logic [HEDEF_W-1:0] hedef_yukseklik_i;
  logic               yukseklik_bilgisi_i;
  logic               hata_temizle_i;
  logic [1:0]         motor_o;
  logic               yesil_led_o;
  logic               kirmizi_led_o;
  logic [2:0]         durum_o;

  modport master (
    output gnss_i, altimetre_i, hedef_yukseklik_i, yukseklik_bilgisi_i, hata_temizle_i,
    input  motor_o, yesil_led_o, kirmizi_led_o, durum_o
  );

  modport slave (
    input  gnss_i, altimetre_i, hedef_yukseklik_i, yukseklik_bilgisi_i, hata_temizle_i,
    output motor_o, yesil_led_o, kirmizi_led_o, durum_o
  );
endinterface

// File: rtl/otopilot_kontrol_gen.sv
// Altitude autopilot: fuses GNSS and barometric altitude, steers the motor into a tolerance
// band around a latched target, confirms arrival, and raises a sticky fault on bad input.
module otopilot_kontrol_gen #(
  parameter int ALT_W      = 16,
  parameter int HEDEF_W    = 8,
  parameter int TOLERANS   = 2,
  parameter int SAPMA_ESIK = 16,
  parameter int ONAY_SAYI  = 3,
  parameter int HATA_SAYI  = 4,
  parameter int MAX_HEDEF  = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  otopilot_kontrol_gen_if.slave bus
);

  typedef enum logic [2:0] {
    BOSTA = 3'd0,
    TAKIP = 3'd1,
    KORU  = 3'd2,
    HATA  = 3'd3
  } durum_e;

  localparam int SW   = ALT_W + 1;
  localparam int CMAX = (ONAY_SAYI > HATA_SAYI) ? ONAY_SAYI : HATA_SAYI;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [SW-1:0]      TOL_W  = SW'(TOLERANS);
  localparam logic [ALT_W-1:0]   ESIK_W = ALT_W'(SAPMA_ESIK);
  localparam logic [HEDEF_W:0]   MAX_W  = (HEDEF_W + 1)'(MAX_HEDEF);
  localparam logic [CW-1:0]      ONAY_W = CW'(ONAY_SAYI);
  localparam logic [CW-1:0]      HATA_W = CW'(HATA_SAYI);
  localparam logic [CW-1:0]      BIR_W  = CW'(1);
  localparam logic [CW-1:0]      SIFIR_W = CW'(0);

  durum_e             durum_q, durum_d;
  logic [HEDEF_W-1:0] hedef_q, hedef_d;
  logic [CW-1:0]      ib_q, ib_d;
  logic [CW-1:0]      ob_q, ob_d;
  logic [CW-1:0]      dis_q, dis_d;
  logic [1:0]         motor_q, motor_d;
  logic               yesil_q, yesil_d;
  logic               kirmizi_q, kirmizi_d;

  logic [SW-1:0]      toplam_s;
  logic [SW-1:0]      fuse_s;
  logic [ALT_W-1:0]   sapma_s;
  logic               hedef_gecersiz_s;
  logic               hedef_yeni_s;
  logic [HEDEF_W-1:0] hedef_etkin_s;
  logic [SW-1:0]      hedef_ext_s;
  logic [SW-1:0]      alt_sinir_s;
  logic [SW-1:0]      ust_sinir_s;
  logic               band_ici_s;
  logic               ayrik_s;
  logic [1:0]         motor_yon_s;
  logic [CW-1:0]      dis_sonraki_s;
  logic [CW-1:0]      ib_sonraki_s;
  logic [CW-1:0]      ob_sonraki_s;

  // Sensor fusion, disagreement and band limits; a freshly strobed valid target applies at once.
  always_comb begin
    toplam_s         = {1'b0, bus.gnss_i} + {1'b0, bus.altimetre_i};
    fuse_s           = toplam_s >> 1;
    if (bus.gnss_i >= bus.altimetre_i) begin
      sapma_s = bus.gnss_i - bus.altimetre_i;
    end else begin
      sapma_s = bus.altimetre_i - bus.gnss_i;
    end
    hedef_gecersiz_s = (bus.hedef_yukseklik_i == {HEDEF_W{1'b0}}) ||
                       ({1'b0, bus.hedef_yukseklik_i} > MAX_W);
    hedef_yeni_s     = bus.yukseklik_bilgisi_i && !hedef_gecersiz_s;
    if (hedef_yeni_s) begin
      hedef_etkin_s = bus.hedef_yukseklik_i;
    end else begin
      hedef_etkin_s = hedef_q;
    end
    hedef_ext_s      = SW'(hedef_etkin_s);
    if (hedef_ext_s > TOL_W) begin
      alt_sinir_s = hedef_ext_s - TOL_W;
    end else begin
      alt_sinir_s = {SW{1'b0}};
    end
    ust_sinir_s      = hedef_ext_s + TOL_W;
    band_ici_s       = (fuse_s >= alt_sinir_s) && (fuse_s <= ust_sinir_s);
    ayrik_s          = (sapma_s > ESIK_W);
    if (fuse_s < alt_sinir_s) begin
      motor_yon_s = 2'b01;
    end else if (fuse_s > ust_sinir_s) begin
      motor_yon_s = 2'b10;
    end else begin
      motor_yon_s = 2'b00;
    end
  end

  // Next-state and counter logic; fault conditions are checked before retarget and band moves.
  always_comb begin
    durum_d       = durum_q;
    hedef_d       = hedef_q;
    ib_d          = ib_q;
    ob_d          = ob_q;
    dis_d         = dis_q;
    dis_sonraki_s = ayrik_s ? (dis_q + BIR_W) : SIFIR_W;
    ib_sonraki_s  = band_ici_s ? (ib_q + BIR_W) : SIFIR_W;
    ob_sonraki_s  = band_ici_s ? SIFIR_W : (ob_q + BIR_W);

    case (durum_q)
      BOSTA: begin
        ib_d  = SIFIR_W;
        ob_d  = SIFIR_W;
        dis_d = SIFIR_W;
        if (bus.yukseklik_bilgisi_i && hedef_gecersiz_s) begin
          durum_d = HATA;
        end else if (bus.yukseklik_bilgisi_i) begin
          durum_d = TAKIP;
          hedef_d = bus.hedef_yukseklik_i;
        end else begin
          durum_d = BOSTA;
        end
      end

      TAKIP, KORU: begin
        if (bus.yukseklik_bilgisi_i && hedef_gecersiz_s) begin
          durum_d = HATA;
          ib_d    = SIFIR_W;
          ob_d    = SIFIR_W;
          dis_d   = SIFIR_W;
        end else if (dis_sonraki_s == HATA_W) begin
          durum_d = HATA;
          ib_d    = SIFIR_W;
          ob_d    = SIFIR_W;
          dis_d   = SIFIR_W;
        end else if (bus.yukseklik_bilgisi_i) begin
          durum_d = TAKIP;
          hedef_d = bus.hedef_yukseklik_i;
          ib_d    = SIFIR_W;
          ob_d    = SIFIR_W;
          dis_d   = SIFIR_W;
        end else if (durum_q == TAKIP) begin
          dis_d = dis_sonraki_s;
          ob_d  = SIFIR_W;
          if (ib_sonraki_s == ONAY_W) begin
            durum_d = KORU;
            ib_d    = SIFIR_W;
          end else begin
            ib_d = ib_sonraki_s;
          end
        end else begin
          dis_d = dis_sonraki_s;
          ib_d  = SIFIR_W;
          if (ob_sonraki_s == ONAY_W) begin
            durum_d = TAKIP;
            ob_d    = SIFIR_W;
          end else begin
            ob_d = ob_sonraki_s;
          end
        end
      end

      HATA: begin
        ib_d  = SIFIR_W;
        ob_d  = SIFIR_W;
        dis_d = SIFIR_W;
        if (bus.hata_temizle_i) begin
          durum_d = BOSTA;
        end else begin
          durum_d = HATA;
        end
      end

      default: begin
        durum_d = BOSTA;
        ib_d    = SIFIR_W;
        ob_d    = SIFIR_W;
        dis_d   = SIFIR_W;
      end
    endcase
  end

  // Outputs follow the state being entered so they appear one edge after the sample.
  always_comb begin
    yesil_d   = (durum_d == KORU);
    kirmizi_d = (durum_d == HATA);
    case (durum_d)
      TAKIP, KORU: motor_d = motor_yon_s;
      default:     motor_d = 2'b00;
    endcase
  end

  // State, target, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q   <= BOSTA;
      hedef_q   <= {HEDEF_W{1'b0}};
      ib_q      <= SIFIR_W;
      ob_q      <= SIFIR_W;
      dis_q     <= SIFIR_W;
      motor_q   <= 2'b00;
      yesil_q   <= 1'b0;
      kirmizi_q <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      hedef_q   <= hedef_d;
      ib_q      <= ib_d;
      ob_q      <= ob_d;
      dis_q     <= dis_d;
      motor_q   <= motor_d;
      yesil_q   <= yesil_d;
      kirmizi_q <= kirmizi_d;
    end
  end

  assign bus.motor_o       = motor_q;
  assign bus.yesil_led_o   = yesil_q;
  assign bus.kirmizi_led_o = kirmizi_q;
  assign bus.durum_o       = durum_q;

endmodule

// File: tb/tb_otopilot_kontrol_gen.sv
// Scenario bench for otopilot_kontrol_gen: expected {motor, yesil, kirmizi, durum} is queued
// as each sample is driven and popped after the following rising edge.
module tb_otopilot_kontrol_gen;

  typedef struct packed {
    logic [15:0] g;
    logic [15:0] a;
    logic        b;
    logic [7:0]  h;
    logic        t;
    logic [6:0]  exp;
  } row_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [6:0] sb[$];

  otopilot_kontrol_gen_if #(.ALT_W(16), .HEDEF_W(8)) bus ();

  otopilot_kontrol_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic row_t r(input logic [15:0] g, input logic [15:0] a, input logic b,
                             input logic [7:0] h, input logic t, input logic [1:0] m,
                             input logic y, input logic k, input logic [2:0] d);
    r = {g, a, b, h, t, m, y, k, d};
  endfunction

  function automatic logic [6:0] obs();
    obs = {bus.motor_o, bus.yesil_led_o, bus.kirmizi_led_o, bus.durum_o};
  endfunction

  task automatic drive(input row_t x);
    bus.gnss_i              = x.g;
    bus.altimetre_i         = x.a;
    bus.yukseklik_bilgisi_i = x.b;
    bus.hedef_yukseklik_i   = x.h;
    bus.hata_temizle_i      = x.t;
    sb.push_back(x.exp);
  endtask

  task automatic test_reset();
    logic [6:0] e;
    rst_n = 1'b0;
    drive(r(16'd0, 16'd0, 1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0));
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL reset_state: got %b want %b", obs(), e);
    end
    rst_n = 1'b1;
    drive(r(16'd50, 16'd50, 1'b1, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL reset_latch: got %b want %b", obs(), e);
    end
    drive(r(16'd20, 16'd36, 1'b0, 8'd50, 1'b0, 2'b01, 1'b0, 1'b0, 3'd1));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL reset_climb: got %b want %b", obs(), e);
    end
    #3;
    rst_n = 1'b0;
    sb.push_back(7'b00_0_0_000);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL reset_async: got %b want %b", obs(), e);
    end
    @(posedge clk);
    #1;
    drive(r(16'd0, 16'd0, 1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL reset_release_idle: got %b want %b", obs(), e);
    end
  endtask

  task automatic test_invalid_target();
    row_t rows[$];
    logic [6:0] e;
    rows.push_back(r(16'd0,   16'd0,   1'b1, 8'd110, 1'b0, 2'b00, 1'b0, 1'b1, 3'd3));
    rows.push_back(r(16'd0,   16'd0,   1'b1, 8'd50,  1'b0, 2'b00, 1'b0, 1'b1, 3'd3));
    rows.push_back(r(16'd0,   16'd0,   1'b0, 8'd50,  1'b1, 2'b00, 1'b0, 1'b0, 3'd0));
    rows.push_back(r(16'd0,   16'd0,   1'b1, 8'd0,   1'b0, 2'b00, 1'b0, 1'b1, 3'd3));
    rows.push_back(r(16'd0,   16'd0,   1'b0, 8'd0,   1'b1, 2'b00, 1'b0, 1'b0, 3'd0));
    rows.push_back(r(16'd0,   16'd0,   1'b1, 8'd101, 1'b0, 2'b00, 1'b0, 1'b1, 3'd3));
    rows.push_back(r(16'd0,   16'd0,   1'b0, 8'd0,   1'b1, 2'b00, 1'b0, 1'b0, 3'd0));
    rows.push_back(r(16'd100, 16'd100, 1'b1, 8'd100, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd100, 16'd100, 1'b1, 8'd0,   1'b0, 2'b00, 1'b0, 1'b1, 3'd3));
    rows.push_back(r(16'd0,   16'd0,   1'b0, 8'd0,   1'b1, 2'b00, 1'b0, 1'b0, 3'd0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL invalid_target row %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_motor();
    row_t rows[$];
    logic [6:0] e;
    rows.push_back(r(16'd50, 16'd50, 1'b1, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd20, 16'd36, 1'b0, 8'd50, 1'b0, 2'b01, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd56, 16'd72, 1'b0, 8'd50, 1'b0, 2'b10, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd48, 16'd48, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd52, 16'd52, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd53, 16'd53, 1'b0, 8'd50, 1'b0, 2'b10, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd47, 16'd47, 1'b0, 8'd50, 1'b0, 2'b01, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd47, 16'd47, 1'b1, 8'd0,  1'b0, 2'b00, 1'b0, 1'b1, 3'd3));
    rows.push_back(r(16'd0,  16'd0,  1'b0, 8'd0,  1'b1, 2'b00, 1'b0, 1'b0, 3'd0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL motor_band row %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_confirm();
    row_t rows[$];
    logic [6:0] e;
    rows.push_back(r(16'd50, 16'd50, 1'b1, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd60, 16'd60, 1'b0, 8'd50, 1'b0, 2'b10, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd60, 16'd60, 1'b0, 8'd50, 1'b0, 2'b10, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd60, 16'd60, 1'b0, 8'd50, 1'b0, 2'b10, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd60, 16'd60, 1'b0, 8'd50, 1'b0, 2'b10, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd60, 16'd60, 1'b0, 8'd50, 1'b0, 2'b10, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd60, 16'd60, 1'b0, 8'd50, 1'b0, 2'b10, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd46, 16'd52, 1'b1, 8'd0,  1'b0, 2'b00, 1'b0, 1'b1, 3'd3));
    rows.push_back(r(16'd0,  16'd0,  1'b0, 8'd0,  1'b1, 2'b00, 1'b0, 1'b0, 3'd0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL confirm row %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_disagree();
    row_t rows[$];
    logic [6:0] e;
    rows.push_back(r(16'd50, 16'd50, 1'b1, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd0,  16'd20, 1'b0, 8'd50, 1'b0, 2'b01, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd36, 16'd60, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd36, 16'd60, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd36, 16'd60, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b1, 3'd3));
    rows.push_back(r(16'd0,  16'd0,  1'b0, 8'd0,  1'b1, 2'b00, 1'b0, 1'b0, 3'd0));
    rows.push_back(r(16'd50, 16'd50, 1'b1, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd36, 16'd60, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd36, 16'd60, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd36, 16'd60, 1'b0, 8'd50, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd45, 16'd45, 1'b0, 8'd50, 1'b0, 2'b01, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd36, 16'd60, 1'b0, 8'd50, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd36, 16'd60, 1'b0, 8'd50, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd36, 16'd60, 1'b0, 8'd50, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd36, 16'd60, 1'b0, 8'd50, 1'b0, 2'b00, 1'b0, 1'b1, 3'd3));
    rows.push_back(r(16'd0,  16'd0,  1'b0, 8'd0,  1'b1, 2'b00, 1'b0, 1'b0, 3'd0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL disagree row %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_retarget();
    row_t rows[$];
    logic [6:0] e;
    rows.push_back(r(16'd46, 16'd52, 1'b1, 8'd50,  1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50,  1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50,  1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd50,  1'b0, 2'b00, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd46, 16'd52, 1'b1, 8'd30,  1'b0, 2'b10, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd46, 16'd52, 1'b0, 8'd0,   1'b0, 2'b10, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd0,  16'd0,  1'b1, 8'd1,   1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd0,  16'd0,  1'b0, 8'd1,   1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd0,  16'd0,  1'b0, 8'd1,   1'b0, 2'b00, 1'b0, 1'b0, 3'd1));
    rows.push_back(r(16'd0,  16'd0,  1'b0, 8'd1,   1'b0, 2'b00, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd4,  16'd4,  1'b0, 8'd1,   1'b0, 2'b10, 1'b1, 1'b0, 3'd2));
    rows.push_back(r(16'd4,  16'd4,  1'b1, 8'd200, 1'b0, 2'b00, 1'b0, 1'b1, 3'd3));
    rows.push_back(r(16'd0,  16'd0,  1'b0, 8'd0,   1'b1, 2'b00, 1'b0, 1'b0, 3'd0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL retarget row %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.gnss_i              = 16'd0;
    bus.altimetre_i         = 16'd0;
    bus.hedef_yukseklik_i   = 8'd0;
    bus.yukseklik_bilgisi_i = 1'b0;
    bus.hata_temizle_i      = 1'b0;
    test_reset();
    test_invalid_target();
    test_motor();
    test_confirm();
    test_disagree();
    test_retarget();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
